argmax_seq: RTL and testbench

- Sequential argmax controller. Streams one signed score per cycle through a single shared signed compare-with-data stage and tracks the running maximum together with its element index.
- After N_IN elements, presents the winning value and index on a valid/ready output.
- Sits after the output layer to turn N_IN class scores into a class index.

---
 rtl/argmax_seq.sv | 138 +++++++++++++
 tb/tb_argmax_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : argmax_seq
// Purpose  : Sequential argmax. Streams one signed score per accepted cycle
//            through a single signed compare stage and tracks the running
//            maximum and its arrival index. After a full frame the winner
//            is offered on a valid/ready output. Ties keep the lower index.
// Options  : ARGMAX_SEQ_IN_LAST_EN - adds in_last, which ends a frame early
//            (frames of 1..N_IN elements).
// Revision : 1.0 - initial release
// ============================================================================
module argmax_seq #(
    parameter  int NUM_W = 8,
    parameter  int N_IN  = 10,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] in_num,
    input  logic             in_valid,
`ifdef ARGMAX_SEQ_IN_LAST_EN
    input  logic             in_last,
`endif
    output logic             in_ready,
    output logic [NUM_W-1:0] out_num,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [0:0]       c_ST_ACCUM  = 1'b0;
    localparam logic [0:0]       c_ST_OUTPUT = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [IDX_W-1:0]        r_count;
    logic signed [NUM_W-1:0] r_best_num;
    logic [IDX_W-1:0]        r_best_idx;
    logic [NUM_W-1:0]        r_out_num;
    logic [IDX_W-1:0]        r_out_idx;

    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_keep_best;
    logic                    w_in_last;
    logic                    w_frame_end;
    logic signed [NUM_W-1:0] w_in_num_s;
    logic signed [NUM_W-1:0] w_sel_num;
    logic [IDX_W-1:0]        w_sel_idx;

`ifdef ARGMAX_SEQ_IN_LAST_EN
    assign w_in_last = in_last;
`else
    assign w_in_last = 1'b0;
`endif

    // Input readiness depends on state alone so it never loops back
    // through in_valid.
    assign w_in_ready = (r_state == c_ST_ACCUM);
    assign w_accept   = in_valid && w_in_ready;

    // Shared compare stage: incumbent (best_num, best_idx) versus the
    // arriving (in_num, count). The first element of a frame loads
    // unconditionally; otherwise the incumbent wins on >= so ties keep
    // the earlier index.
    assign w_in_num_s  = in_num;
    assign w_first     = (r_count == '0);
    assign w_keep_best = !w_first && (r_best_num >= w_in_num_s);
    assign w_sel_num   = w_keep_best ? r_best_num : w_in_num_s;
    assign w_sel_idx   = w_first ? '0 : (w_keep_best ? r_best_idx : r_count);

    // The frame ends on the N_IN-th element or on an early in_last.
    assign w_frame_end = w_accept && ((r_count == c_LAST_IDX) || w_in_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_out_valid  = 1'b0;
        case (r_state)
            c_ST_ACCUM: begin
                if (w_frame_end) begin
                    w_state_next = c_ST_OUTPUT;
                end
            end
            c_ST_OUTPUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = c_ST_ACCUM;
                end
            end
            default: begin
                w_state_next = c_ST_ACCUM;
            end
        endcase
    end

    // Running-maximum datapath; the final comparison goes straight to the
    // output registers, which then hold until the next frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_best_num <= '0;
            r_best_idx <= '0;
            r_out_num  <= '0;
            r_out_idx  <= '0;
        end else if (w_accept) begin
            r_best_num <= w_sel_num;
            r_best_idx <= w_sel_idx;
            if (w_frame_end) begin
                r_count   <= '0;
                r_out_num <= w_sel_num;
                r_out_idx <= w_sel_idx;
            end else begin
                r_count <= r_count + c_IDX_ONE;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_num   = r_out_num;
    assign out_idx   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_seq
// Purpose  : Self-checking bench for argmax_seq against a queue-based
//            argmax reference model. ARGMAX_SEQ_IN_LAST_EN enables the
//            early-termination scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_seq;

    localparam int NUM_W = 8;
    localparam int N_IN  = 10;
    localparam int IDX_W = $clog2(N_IN);

    logic             clk = 1'b0;
    logic             rst;
    logic [NUM_W-1:0] in_num;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [NUM_W-1:0] out_num;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    argmax_seq #(.NUM_W(NUM_W), .N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_num    (in_num),
        .in_valid  (in_valid),
`ifdef ARGMAX_SEQ_IN_LAST_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_num   (out_num),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first occurrence of the largest value.
    function automatic void ref_argmax(input int q[$], output int mx, output int ix);
        mx = q[0];
        ix = 0;
        foreach (q[k]) begin
            if (q[k] > mx) begin
                mx = q[k];
                ix = k;
            end
        end
    endfunction

    // Sends one frame with optional random bubbles, then checks the result.
    // If out_ready is high, also checks the return to ACCUM.
    task automatic drive_frame(input int vals[$], input int bubble_pct,
                               input bit use_last, input string name);
        int mx, ix, guard;
        logic [NUM_W-1:0] e_num;
        logic [IDX_W-1:0] e_idx;
        ref_argmax(vals, mx, ix);
        e_num = NUM_W'(mx);
        e_idx = IDX_W'(ix);
        for (int i = 0; i < vals.size(); i++) begin
            while (int'($urandom_range(0, 99)) < bubble_pct) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_num   = NUM_W'(vals[i]);
            in_last  = use_last && (i == vals.size() - 1);
            guard = 0;
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
            end
            step();
            if (i < vals.size() - 1) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s early_valid elem %0d: out_valid=%b required 0", name, i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s output_state: out_valid=%b in_ready=%b required 1 0", name, out_valid, in_ready);
        end
        n_cmp++;
        if (out_num !== e_num || out_idx !== e_idx) begin
            n_bad++;
            $display("FAIL %s result: num=%0d idx=%0d required num=%0d idx=%0d",
                     name, $signed(out_num), out_idx, $signed(e_num), e_idx);
        end
        if (out_ready === 1'b1) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_num !== e_num || out_idx !== e_idx) begin
                n_bad++;
                $display("FAIL %s release: out_valid=%b in_ready=%b num=%0d idx=%0d required 0 1 %0d %0d",
                         name, out_valid, in_ready, $signed(out_num), out_idx, $signed(e_num), e_idx);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_num = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_num !== '0 || out_idx !== '0) begin
            n_bad++;
            $display("FAIL reset: out_valid=%b in_ready=%b num=%0d idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_num, out_idx);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int q[$];
        q = '{3, -7, 12, 5, 12, 0, -128, 11, 1, 2};
        drive_frame(q, 0, 1'b0, "basic");
    endtask

    task automatic test_boundaries();
        int q[$];
        q = '{};
        for (int i = 0; i < N_IN; i++) q.push_back(-128);
        drive_frame(q, 0, 1'b0, "all_min");
        q = '{};
        for (int i = 0; i < N_IN; i++) q.push_back(i);
        drive_frame(q, 0, 1'b0, "ascending");
        q = '{};
        for (int i = 0; i < N_IN; i++) q.push_back(127 - i);
        drive_frame(q, 0, 1'b0, "descending");
    endtask

    task automatic test_backpressure();
        int q[$];
        q = '{-5, 20, 7, 20, -128, 127, 0, 126, 127, 1};
        out_ready = 1'b0;
        drive_frame(q, 0, 1'b0, "bp_frame");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_num   = NUM_W'($urandom_range(0, 255));
            step();
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_num !== 8'd127 || out_idx !== 4'd5) begin
                n_bad++;
                $display("FAIL bp_hold cyc %0d: in_ready=%b out_valid=%b num=%0d idx=%0d required 0 1 127 5",
                         c, in_ready, out_valid, $signed(out_num), out_idx);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        drive_frame(q, 0, 1'b0, "bp_next");
    endtask

    task automatic test_random_bubbles();
        int q[$];
        for (int f = 0; f < 3; f++) begin
            q = '{};
            for (int i = 0; i < N_IN; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
            drive_frame(q, 50, 1'b0, $sformatf("rand_%0d", f));
        end
    endtask

    task automatic test_reset_abort();
        int q[$];
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_num   = NUM_W'(100 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_num !== '0 || out_idx !== '0) begin
            n_bad++;
            $display("FAIL abort_reset: out_valid=%b in_ready=%b num=%0d idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_num, out_idx);
        end
        q = '{};
        for (int i = 1; i <= N_IN; i++) q.push_back(i);
        drive_frame(q, 0, 1'b0, "after_abort");
        out_ready = 1'b0;
        q = '{4, 4, 9, -1, 9, 3, 2, 2, 8, 0};
        drive_frame(q, 0, 1'b0, "pre_out_reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL output_reset: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        step();
    endtask

`ifdef ARGMAX_SEQ_IN_LAST_EN
    task automatic test_in_last();
        int q[$];
        q = '{5, 9, -1};
        drive_frame(q, 0, 1'b1, "last_3");
        q = '{42};
        drive_frame(q, 0, 1'b1, "last_1");
        q = '{-3, -2, -2, -9, -1, -1, -7};
        drive_frame(q, 30, 1'b1, "last_7");
        q = '{};
        for (int i = 0; i < N_IN; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
        drive_frame(q, 0, 1'b0, "last_full");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_random_bubbles();
        test_reset_abort();
`ifdef ARGMAX_SEQ_IN_LAST_EN
        test_in_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
